// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute ALU: opcodes (with the
// CMP/TST/LDR/STR aliases used by the decoder), FSM states and the bit
// positions of the {Z,C,N,V} status register.
package alu_pkg;

   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;
   localparam logic [3:0] OP_MVN = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;

   // Instructions that reuse an ALU operation
   localparam logic [3:0] OP_CMP = OP_SUB;
   localparam logic [3:0] OP_TST = OP_AND;
   localparam logic [3:0] OP_LDR = OP_ADD;
   localparam logic [3:0] OP_STR = OP_ADD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int Z_BIT = 3;
   localparam int C_BIT = 2;
   localparam int N_BIT = 1;
   localparam int V_BIT = 0;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier. start loads the operands; every following
// cycle adds the shifted multiplicand when the current multiplier bit is set.
// done is high during the final step and product then carries the finished
// low WIDTH bits, so the caller can register it on that same edge.
module seq_mul #(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(ITERS + 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_step;

   assign busy    = (cnt_q != '0);
   assign done    = (cnt_q == CW'(1));
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product = acc_step;

   // Load on start, otherwise advance one partial product per busy cycle
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start) begin
         acc_d    = '0;
         mcand_d  = a;
         mplier_d = b;
         cnt_d    = CW'(ITERS);
      end else if (busy) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
      end
   end

   // Accumulator, shifters and iteration counter; reset drops any partial product
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered EXE-stage ALU with valid/ready on both sides and an NZCV status
// register (carry-in for ADC/SBC comes from it). Single-cycle ops land in
// DONE on the accept edge; MUL iterates in BUSY first.
// Optional feature macro: SEQ_ALU_MUL_EN enables MUL and the BUSY state;
// without it opcode 1010 is treated as illegal.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MUL_ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       exe_cmd,
   input  logic             s_in,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_err,
   output logic [3:0]       status_out
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             err_q, err_d;
   logic [3:0]       status_q, status_d;

   logic [WIDTH:0]   b_ext;
   logic [WIDTH:0]   sum;
   logic             cin;
   logic             is_arith;
   logic             alu_legal;
   logic [WIDTH-1:0] alu_res;
   logic [3:0]       alu_status;

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out        = out_q;
   assign out_err    = err_q;
   assign status_out = status_q;

   // Single-cycle datapath: one WIDTH+1 adder serves ADD/ADC/SUB/SBC
   always_comb begin
      b_ext     = {1'b0, val2};
      cin       = 1'b0;
      is_arith  = 1'b0;
      alu_legal = 1'b1;
      alu_res   = '0;
      case (exe_cmd)
         OP_ADD: is_arith = 1'b1;
         OP_ADC: begin is_arith = 1'b1; cin = status_q[C_BIT]; end
         OP_SUB: begin is_arith = 1'b1; b_ext = {1'b0, ~val2}; cin = 1'b1; end
         OP_SBC: begin is_arith = 1'b1; b_ext = {1'b0, ~val2}; cin = status_q[C_BIT]; end
         default: ;
      endcase
      sum = {1'b0, val1} + b_ext + {{WIDTH{1'b0}}, cin};
      case (exe_cmd)
         OP_MOV:                         alu_res = val2;
         OP_MVN:                         alu_res = ~val2;
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: alu_res = sum[WIDTH-1:0];
         OP_AND:                         alu_res = val1 & val2;
         OP_ORR:                         alu_res = val1 | val2;
         OP_EOR:                         alu_res = val1 ^ val2;
         default:                        alu_legal = 1'b0;
      endcase
      // Z/N from every legal op; C/V only from the adder ops
      alu_status        = status_q;
      alu_status[Z_BIT] = (alu_res == '0);
      alu_status[N_BIT] = alu_res[WIDTH-1];
      if (is_arith) begin
         alu_status[C_BIT] = sum[WIDTH];
         alu_status[V_BIT] = (val1[WIDTH-1] == b_ext[WIDTH-1]) &&
                             (sum[WIDTH-1] != val1[WIDTH-1]);
      end
   end

`ifdef SEQ_ALU_MUL_EN
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_prod;
   logic             s_q, s_d;

   seq_mul #(
      .WIDTH (WIDTH),
      .ITERS (MUL_ITERS)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (val1),
      .b       (val2),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );
`endif

   // Next-state / next-output logic for the IDLE -> (BUSY) -> DONE handshake
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      err_d    = err_q;
      status_d = status_q;
`ifdef SEQ_ALU_MUL_EN
      mul_start = 1'b0;
      s_d       = s_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = DONE;
               out_d   = alu_res;
               err_d   = ~alu_legal;
               if (alu_legal && s_in) status_d = alu_status;
`ifdef SEQ_ALU_MUL_EN
               if (exe_cmd == OP_MUL) begin
                  state_d   = BUSY;
                  mul_start = 1'b1;
                  s_d       = s_in;
                  out_d     = '0;
                  err_d     = 1'b0;
                  status_d  = status_q;
               end
`endif
            end
         end
`ifdef SEQ_ALU_MUL_EN
         BUSY: begin
            if (mul_done) begin
               state_d = DONE;
               out_d   = mul_prod;
               err_d   = 1'b0;
               if (s_q) begin
                  status_d[Z_BIT] = (mul_prod == '0);
                  status_d[N_BIT] = mul_prod[WIDTH-1];
               end
            end else if (!mul_busy) begin
               // Multiplier idle while we wait on it: give up rather than hang
               state_d = IDLE;
            end
         end
`endif
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and output registers; reset overrides everything including BUSY
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         out_q    <= '0;
         err_q    <= 1'b0;
         status_q <= 4'b0000;
`ifdef SEQ_ALU_MUL_EN
         s_q      <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         err_q    <= err_d;
         status_q <= status_d;
`ifdef SEQ_ALU_MUL_EN
         s_q      <= s_d;
`endif
      end
   end

endmodule
